shift_reg_ctrl: RTL and testbench
=================================

Name: shift_reg_ctrl

Overview:
Command sequencer for the team's WIDTH-bit universal shift register.
- Accepts one command per valid/ready handshake: parallel load, shift left, shift right or rotate left, with a step count.
- Drives the register's mode, enable, parallel-data and serial-in pins cycle by cycle.
- Pulses done when the sequence completes.
- Sits between the test/probe logic and the shift-register datapath.

Parameters:
- WIDTH, 4, data width of the controlled shift register.
- CNT_W, 3, width of the step-count field; maximum 2^CNT_W-1 shifts per command.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 LOAD, 01 SHL, 10 SHR, 11 ROL.
- cmd_len  in  CNT_W  number of shift steps after the load.
- cmd_data  in  WIDTH  value loaded before shifting.
- cmd_sin  in  1  serial-in bit for SHL/SHR.
- sr_q  in  WIDTH  current shift-register contents; used for ROL feedback.
- sr_mode  out  2  register mode: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- sr_enable  out  1  register clock-enable.
- sr_din  out  WIDTH  parallel load data.
- sr_sin  out  1  serial input to the register.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; op, len, data and sin latches cleared.
  - Outputs: sr_mode=00, sr_enable=0, sr_din=0, sr_sin=0, busy=0, done=0.
  - cmd_ready=0 while reset is low; cmd_ready=1 from the first cycle after release.
- State machine: IDLE -> LOAD -> SHIFT -> DONE -> IDLE. Outputs are Moore, decoded from registered state and latches only.
- IDLE:
  - cmd_ready=1, busy=0.
  - On clk edge with cmd_valid & cmd_ready: latch op, len, data and sin into internal registers, then go to LOAD.
- LOAD (1 cycle):
  - sr_mode=11, sr_enable=1, sr_din=latched data, busy=1.
  - Step counter loaded with len.
  - If len==0 or op==LOAD, go to DONE; otherwise go to SHIFT.
- SHIFT (len cycles):
  - sr_enable=1, busy=1.
  - SHL: sr_mode=01, sr_sin=latched sin.
  - SHR: sr_mode=10, sr_sin=latched sin.
  - ROL: sr_mode=01, sr_sin=sr_q[WIDTH-1].
  - Counter decrements each cycle; go to DONE in the cycle the counter reaches 1.
- DONE (1 cycle): done=1, busy=1, sr_enable=0, sr_mode=00; then IDLE.
- Timing, with the handshake at edge T:
  - LOAD drives the register during cycle T+1.
  - Shifts occupy cycles T+2 .. T+1+len.
  - done is high in cycle T+2+len.
  - Next acceptance edge is T+3+len at the earliest.
- cmd_ready is low in LOAD, SHIFT and DONE. Inputs outside the accept edge are ignored; cmd_* may change freely during a command.
- Width/boundary rules:
  - len is unsigned; len=2^CNT_W-1 is legal.
  - len>=WIDTH is legal: the register fills entirely with sin (SHL/SHR), and ROL wraps modulo WIDTH.
- Reset asserted mid-command: immediate return to IDLE with reset outputs; no done pulse; any partial register contents are left as they are.

Optional Feature:
SHIFT_CTRL_ABORT_EN
- With the macro defined: an extra input port abort (1 bit) exists. abort=1 sampled in LOAD or SHIFT forces the next state to DONE; done pulses as usual and an extra output aborted (1 bit) is high in that same DONE cycle. abort has no effect in IDLE or DONE.
- Without the macro: neither port exists and commands always run to completion.

Decomposition:
- Package shift_ctrl_pkg contains:
  - op codes OP_LOAD, OP_SHL, OP_SHR, OP_ROL;
  - mode codes MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD;
  - state encoding S_IDLE, S_LOAD, S_SHIFT, S_DONE.
- One sub-module, shift_step_cnt: a CNT_W-bit loadable down-counter with load, dec and last (count==1) outputs.
- The FSM and output decode stay in shift_reg_ctrl.

Test Plan:
Bench: shift_reg_ctrl plus a 4-bit shift-register model, WIDTH=4, CNT_W=3.
1. LOAD, data=1011, len=0: T+1 sr_mode=11, sr_din=1011; T+2 done=1; register=1011; cmd_ready=1 at T+3.
2. SHL, data=0011, len=2, sin=1: register 0011 -> 0111 -> 1111; done at T+4.
3. SHR, data=1100, len=7, sin=0: register reaches 0000 after 4 shifts and holds 0000 through shift 7; done at T+9.
4. ROL, data=1000, len=5: sequence 1000, 0001, 0010, 0100, 1000, 0001; final 0001.
5. cmd_valid held high with two back-to-back SHL len=1 commands: second accepted exactly one cycle after the first done; no command lost or duplicated.
6. Reset pulled low during SHIFT step 2 of a len=6 command: outputs reach reset values asynchronously, no done pulse, cmd_ready=1 the cycle after release. With ABORT_EN, abort during SHIFT gives done=1 and aborted=1 the following cycle.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
//==========================================================================
// shift_ctrl_pkg - op, register-mode and FSM state codes for shift_reg_ctrl
// Revision: 1.0
//==========================================================================
`default_nettype none

package shift_ctrl_pkg;

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_SHL    = 2'b01;
   localparam logic [1:0] OP_SHR    = 2'b10;
   localparam logic [1:0] OP_ROL    = 2'b11;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHL  = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOAD    = 2'd1;
   localparam logic [1:0] S_SHIFT   = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/shift_reg_ctrl_if.sv
//==========================================================================
// shift_reg_ctrl_if - command valid/ready bundle into the shift sequencer
// Revision: 1.0
//==========================================================================
`default_nettype none

interface shift_reg_ctrl_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_len;
   logic [WIDTH-1:0] cmd_data;
   logic             cmd_sin;

   modport master (
      output cmd_valid, cmd_op, cmd_len, cmd_data, cmd_sin,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_len, cmd_data, cmd_sin,
      output cmd_ready
   );
endinterface

`default_nettype wire

// File: rtl/shift_step_cnt.sv
//==========================================================================
// shift_step_cnt - loadable down-counter; last_o flags the final shift step
// Revision: 1.0
//==========================================================================
`default_nettype none

module shift_step_cnt #(
   parameter int CNT_W = 3
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             load_i,
   input  wire logic             dec_i,
   input  wire logic [CNT_W-1:0] len_i,
   output logic                  last_o
);
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = len_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last_o = (count_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/shift_reg_ctrl.sv
//==========================================================================
// shift_reg_ctrl - command sequencer for a universal shift register.
// Optional abort input/aborted output: define SHIFT_CTRL_ABORT_EN.  Rev 1.0
//==========================================================================
`default_nettype none

module shift_reg_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  wire logic             clk,
   input  wire logic             reset,
   shift_reg_ctrl_if.slave       cmd,
   input  wire logic [WIDTH-1:0] sr_q,
   output logic [1:0]            sr_mode,
   output logic                  sr_enable,
   output logic [WIDTH-1:0]      sr_din,
   output logic                  sr_sin,
   output logic                  busy,
   output logic                  done
`ifdef SHIFT_CTRL_ABORT_EN
   ,
   input  wire logic             abort,
   output logic                  aborted
`endif
);
   logic [1:0]       state_q, state_d;
   logic [1:0]       op_q,    op_d;
   logic [CNT_W-1:0] len_q,   len_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic             sin_q,   sin_d;
   logic             rdy_q;
   logic             w_last;
   logic             w_abort;
   logic             w_accept;
   logic             w_unused_sr_q;

   // Only the MSB feeds ROL; the rest of the register is observed, not used.
   assign w_unused_sr_q = ^sr_q[WIDTH-2:0];

`ifdef SHIFT_CTRL_ABORT_EN
   logic aborted_q;

   assign w_abort = abort && ((state_q == S_LOAD) || (state_q == S_SHIFT));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         aborted_q <= 1'b0;
      end else begin
         aborted_q <= w_abort;
      end
   end

   assign aborted = aborted_q && (state_q == S_DONE);
`else
   assign w_abort = 1'b0;
`endif

   shift_step_cnt #(.CNT_W(CNT_W)) u_step_cnt (
      .clk    (clk),
      .reset  (reset),
      .load_i (state_q == S_LOAD),
      .dec_i  (state_q == S_SHIFT),
      .len_i  (len_q),
      .last_o (w_last)
   );

   // rdy_q keeps cmd_ready low while reset is held and for no longer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_q <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
      end
   end

   assign cmd.cmd_ready = rdy_q && (state_q == S_IDLE);
   assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      len_d   = len_q;
      data_d  = data_q;
      sin_d   = sin_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               op_d    = cmd.cmd_op;
               len_d   = cmd.cmd_len;
               data_d  = cmd.cmd_data;
               sin_d   = cmd.cmd_sin;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_abort || (len_q == '0) || (op_q == OP_LOAD)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_abort || w_last) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q    <= OP_LOAD;
         len_q   <= '0;
         data_q  <= '0;
         sin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         len_q   <= len_d;
         data_q  <= data_d;
         sin_q   <= sin_d;
      end
   end

   always_comb begin
      sr_mode   = MODE_HOLD;
      sr_enable = 1'b0;
      sr_din    = '0;
      sr_sin    = 1'b0;
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      case (state_q)
         S_LOAD: begin
            sr_mode   = MODE_LOAD;
            sr_enable = 1'b1;
            sr_din    = data_q;
         end
         S_SHIFT: begin
            sr_enable = 1'b1;
            case (op_q)
               OP_SHL: begin
                  sr_mode = MODE_SHL;
                  sr_sin  = sin_q;
               end
               OP_SHR: begin
                  sr_mode = MODE_SHR;
                  sr_sin  = sin_q;
               end
               OP_ROL: begin
                  sr_mode = MODE_SHL;
                  sr_sin  = sr_q[WIDTH-1];
               end
               default: sr_mode = MODE_HOLD;
            endcase
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_ctrl.sv
//==========================================================================
// tb_shift_reg_ctrl - directed bench: shift_reg_ctrl driving a 4-bit model
// Revision: 1.0
//==========================================================================
`default_nettype none

module tb_shift_reg_ctrl;
   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] sr_q  = 4'b0000;
   logic [1:0] sr_mode;
   logic       sr_enable;
   logic [3:0] sr_din;
   logic       sr_sin;
   logic       busy;
   logic       done;
`ifdef SHIFT_CTRL_ABORT_EN
   logic       abort = 1'b0;
   logic       aborted;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int n_acc    = 0;
   int n_done   = 0;

   shift_reg_ctrl_if #(.WIDTH(4), .CNT_W(3)) cmd_if ();

   shift_reg_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd       (cmd_if),
      .sr_q      (sr_q),
      .sr_mode   (sr_mode),
      .sr_enable (sr_enable),
      .sr_din    (sr_din),
      .sr_sin    (sr_sin),
      .busy      (busy),
      .done      (done)
`ifdef SHIFT_CTRL_ABORT_EN
      ,
      .abort     (abort),
      .aborted   (aborted)
`endif
   );

   always #5 clk = ~clk;

   // Reference universal shift register; not reset, so partial contents persist.
   always @(posedge clk) begin
      if (sr_enable) begin
         case (sr_mode)
            2'b01:   sr_q <= {sr_q[2:0], sr_sin};
            2'b10:   sr_q <= {sr_sin, sr_q[3:1]};
            2'b11:   sr_q <= sr_din;
            default: sr_q <= sr_q;
         endcase
      end
   end

   always @(posedge clk) begin
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) n_acc++;
      if (done) n_done++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts and ends at a negedge with the DUT idle; seq nibble k = register after k shifts.
   task automatic run_cmd(input string name, input logic [1:0] op, input logic [2:0] len,
                          input logic [3:0] data, input logic sin, input logic [31:0] seq);
      logic [3:0] cur;
      logic [1:0] emode;
      int         nsh;
      nsh = (op == 2'b00) ? 0 : int'(len);
      check({name, " ready"}, 32'(cmd_if.cmd_ready), 32'd1);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_len   = len;
      cmd_if.cmd_data  = data;
      cmd_if.cmd_sin   = sin;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_data  = ~data;
      check({name, " load mode"}, 32'(sr_mode), 32'd3);
      check({name, " load din"}, 32'(sr_din), 32'(data));
      check({name, " load busy"}, 32'({busy, sr_enable, cmd_if.cmd_ready}), 32'b110);
      emode = (op == 2'b10) ? 2'b10 : 2'b01;
      for (int i = 1; i <= nsh; i++) begin
         @(negedge clk);
         cur = seq[4*(i-1) +: 4];
         check({name, " shift mode"}, 32'(sr_mode), 32'(emode));
         check({name, " shift sin"}, 32'(sr_sin), 32'((op == 2'b11) ? cur[3] : sin));
         check({name, " shift reg"}, 32'(sr_q), 32'(cur));
         check({name, " shift en/done"}, 32'({sr_enable, done}), 32'b10);
      end
      @(negedge clk);
      check({name, " done"}, 32'({done, busy, sr_enable, sr_mode}), 32'b11000);
      check({name, " final reg"}, 32'(sr_q), 32'(seq[4*nsh +: 4]));
      @(negedge clk);
      check({name, " ready after"}, 32'({cmd_if.cmd_ready, done, busy}), 32'b100);
   endtask

   initial begin
      int acc0;
      int done0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 2'b00;
      cmd_if.cmd_len   = 3'd0;
      cmd_if.cmd_data  = 4'h0;
      cmd_if.cmd_sin   = 1'b0;

      repeat (2) @(negedge clk);
      check("reset outs", 32'({sr_mode, sr_enable, sr_din, sr_sin, busy, done}), 32'd0);
      check("reset ready", 32'(cmd_if.cmd_ready), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      run_cmd("LOAD len0", 2'b00, 3'd0, 4'b1011, 1'b0, 32'h0000000B);
      run_cmd("LOAD len5", 2'b00, 3'd5, 4'b0101, 1'b1, 32'h00000005);
      run_cmd("SHL len2",  2'b01, 3'd2, 4'b0011, 1'b1, 32'h00000F73);
      run_cmd("SHR len7",  2'b10, 3'd7, 4'b1100, 1'b0, 32'h0000136C);
      run_cmd("ROL len5",  2'b11, 3'd5, 4'b1000, 1'b0, 32'h00184218);

      // Back-to-back with cmd_valid held high.
      acc0 = n_acc;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 2'b01;
      cmd_if.cmd_len   = 3'd1;
      cmd_if.cmd_data  = 4'b0001;
      cmd_if.cmd_sin   = 1'b0;
      @(negedge clk);
      check("b2b load1 din", 32'(sr_din), 32'h1);
      cmd_if.cmd_data = 4'b0010;
      cmd_if.cmd_sin  = 1'b1;
      @(negedge clk);
      check("b2b shift1 mode", 32'({sr_mode, sr_enable}), 32'b011);
      @(negedge clk);
      check("b2b done1", 32'({done, cmd_if.cmd_ready}), 32'b10);
      check("b2b reg1", 32'(sr_q), 32'h2);
      @(negedge clk);
      check("b2b idle gap", 32'({cmd_if.cmd_ready, busy}), 32'b10);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      check("b2b load2", 32'({sr_mode, sr_din}), 32'b11_0010);
      @(negedge clk);
      @(negedge clk);
      check("b2b done2", 32'(done), 32'd1);
      check("b2b reg2", 32'(sr_q), 32'h5);
      @(negedge clk);
      check("b2b accepts", 32'(n_acc - acc0), 32'd2);

`ifdef SHIFT_CTRL_ABORT_EN
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 2'b01;
      cmd_if.cmd_len   = 3'd5;
      cmd_if.cmd_data  = 4'b0000;
      cmd_if.cmd_sin   = 1'b1;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort done", 32'({done, aborted, busy}), 32'b111);
      check("abort reg", 32'(sr_q), 32'h1);
      @(negedge clk);
      check("abort idle", 32'({cmd_if.cmd_ready, aborted, done}), 32'b100);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort in idle", 32'({cmd_if.cmd_ready, aborted, done, busy}), 32'b1000);
`endif

      // Reset during the second shift of a len=6 command.
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 2'b01;
      cmd_if.cmd_len   = 3'd6;
      cmd_if.cmd_data  = 4'b0000;
      cmd_if.cmd_sin   = 1'b1;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      done0 = n_done;
      reset = 1'b0;
      #1;
      check("midrst outs", 32'({sr_mode, sr_enable, sr_din, sr_sin, busy, done}), 32'd0);
      check("midrst ready", 32'(cmd_if.cmd_ready), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst ready after", 32'({cmd_if.cmd_ready, busy}), 32'b10);
      check("midrst partial reg", 32'(sr_q), 32'h1);
      repeat (3) @(negedge clk);
      check("midrst no done", 32'(n_done - done0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
